// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic [DATA_W-1:0] w_head;

    // Flags come from the registered count only, never from same-cycle requests.
    assign w_full       = (r_count == PW'(DEPTH));
    assign w_empty      = (r_count == PW'(0));
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= PW'(AF_THRESH));
    assign almost_empty = (r_count <= PW'(AE_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A pop accepted while full frees a slot, so a simultaneous push also proceeds.
    assign w_pop_ok  = rd_en && !w_empty;
    assign w_push_ok = wr_en && (!w_full || w_pop_ok);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        data_out = r_data_out;
        if (FWFT) begin
            data_out = w_empty ? DATA_W'(0) : w_head;
        end
    end

    // Pointers, occupancy, registered read data and error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= PW'(0);
            r_rd_ptr    <= PW'(0);
            r_count     <= PW'(0);
            r_data_out  <= DATA_W'(0);
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_data_out <= w_head;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en && !w_push_ok;
            r_underflow <= rd_en && !w_pop_ok;
        end
    end

    // Storage is not reset; writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share stimulus and
// are compared against a queue-based reference model plus a hand-computed vector table.
module tb_sync_fifo_param;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 3;
    localparam int unsigned AF  = 2;
    localparam int unsigned AE  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] s_count, f_count;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_std = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        int            exp_cnt;
        logic [DW-1:0] exp_dout;
        logic [DW-1:0] exp_fwft;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic wr, input logic [DW-1:0] din, input logic rd, input logic rst);
        logic pop_ok, push_ok;
        if (!rst) begin
            q.delete();
            m_std = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = rd && (q.size() > 0);
            push_ok = wr && ((q.size() < DEP) || pop_ok);
            m_ovf   = wr && !push_ok;
            m_udf   = rd && !pop_ok;
            if (pop_ok) m_std = q.pop_front();
            if (push_ok) q.push_back(din);
        end
    endtask

    task automatic check_dut(input string tag, input int cnt, input int dout, input int fl, input int em,
                             input int af, input int ae, input int ov, input int un, input int exp_dout);
        int n;
        n = q.size();
        chk({tag, "_count"}, cnt, n);
        chk({tag, "_full"}, fl, int'(n == DEP));
        chk({tag, "_empty"}, em, int'(n == 0));
        chk({tag, "_afull"}, af, int'(n >= AF));
        chk({tag, "_aempty"}, ae, int'(n <= AE));
        chk({tag, "_overflow"}, ov, int'(m_ovf));
        chk({tag, "_underflow"}, un, int'(m_udf));
        chk({tag, "_dout"}, dout, exp_dout);
    endtask

    task automatic check_model();
        int fw;
        fw = (q.size() > 0) ? int'(q[0]) : 0;
        check_dut("std", int'(s_count), int'(s_dout), int'(s_full), int'(s_empty), int'(s_af),
                  int'(s_ae), int'(s_ovf), int'(s_udf), int'(m_std));
        check_dut("fwft", int'(f_count), int'(f_dout), int'(f_full), int'(f_empty), int'(f_af),
                  int'(f_ae), int'(f_ovf), int'(f_udf), fw);
    endtask

    task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic rst);
        @(negedge clk);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        rst_n   = rst;
        @(posedge clk);
        model_update(wr, din, rd, rst);
        #1;
        check_model();
    endtask

    initial begin
        // wr, din, rd, count, std dout, fwft dout, ovf, udf  (AF=2, AE=2, DEPTH=4)
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 2, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 3, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 4, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h66, 1'b0, 4, 8'h00, 8'h11, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 4, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 3, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 2, 8'h22, 8'h33, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1, 8'h33, 8'h44, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 0, 8'h44, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 8'h44, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 0, 8'h44, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h11, 1'b0, 1, 8'h44, 8'h11, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h22, 1'b0, 2, 8'h44, 8'h11, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h33, 1'b0, 3, 8'h44, 8'h11, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h44, 1'b0, 4, 8'h44, 8'h11, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'h55, 1'b1, 4, 8'h11, 8'h22, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 3, 8'h22, 8'h33, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 2, 8'h33, 8'h44, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1, 8'h44, 8'h55, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 0, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 8'hA5, 1'b1, 1, 8'h55, 8'hA5, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 0, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 8'h3C, 1'b0, 1, 8'hA5, 8'h3C, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 8'h00, 1'b1, 0, 8'h3C, 8'h00, 1'b0, 1'b0};

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_empty", int'(s_empty), 1);
        chk("rst_aempty", int'(s_ae), 1);
        chk("rst_full", int'(s_full), 0);
        chk("rst_afull", int'(s_af), 0);
        chk("rst_fwft_dout", int'(f_dout), 0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b1);
            chk($sformatf("vec%0d_count", i), int'(s_count), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_std_dout", i), int'(s_dout), int'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_fwft_dout", i), int'(f_dout), int'(vecs[i].exp_fwft));
            chk($sformatf("vec%0d_overflow", i), int'(s_ovf), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_underflow", i), int'(s_udf), int'(vecs[i].exp_udf));
        end

        // Overlapped stream of 10 words, then a one-cycle reset mid-stream
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(8'hC0 + i), (i >= 2), 1'b1);
            if (i >= 2) chk($sformatf("stream%0d_order", i), int'(s_dout), 8'hC0 + i - 2);
            chk($sformatf("stream%0d_count_max", i), int'(s_count <= CW'(DEP)), 1);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("midrst_count", int'(s_count), 0);
        chk("midrst_empty", int'(s_empty), 1);
        chk("midrst_std_dout", int'(s_dout), 0);
        chk("midrst_fwft_dout", int'(f_dout), 0);
        step(1'b1, 8'h7E, 1'b0, 1'b1);
        chk("postrst_fwft_head", int'(f_dout), 8'h7E);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("postrst_std_dout", int'(s_dout), 8'h7E);
        chk("postrst_empty", int'(s_empty), 1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic wr, rd, rst;
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 50);
            rst = ($urandom_range(0, 99) != 0);
            step(wr, DW'($urandom), rd, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
